fifo_downsizer: RTL and testbench
=================================

# fifo_downsizer

Width-down converter placed directly downstream of the lookahead `fifo`. It pops `DATA_WIDTH`-bit words from the FIFO's first-word-fall-through read port and emits them as `OUT_WIDTH`-bit slices on a valid/ready stream. A word is popped in the same cycle its last slice is accepted, so sustained throughput is one slice per clock with no bubble between words.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: FIFO word width.
- `OUT_WIDTH`, 8: slice width. Must divide `DATA_WIDTH`. `RATIO = DATA_WIDTH/OUT_WIDTH` is a derived localparam.
- `MSB_FIRST`, 0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.

**Ports**
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_dout`, input, `DATA_WIDTH`: FIFO head word. Valid whenever `!fifo_empty` (lookahead).
- `fifo_rd`, output, 1: pop strobe to the FIFO.
- `o_valid`, output, 1: slice valid.
- `o_ready`, input, 1: downstream accepts the slice.
- `o_data`, output, `OUT_WIDTH`: current slice.
- `o_last`, output, 1: current slice is the final slice of its word.

## Operation

- State:
  - `buf` is a `DATA_WIDTH`-bit register.
  - `buf_valid` is a 1-bit register.
  - `cnt` is a `max(1,clog2(RATIO))`-bit slice index.
- Handshakes:
  - `accept = o_valid & o_ready`.
  - `drain = accept & (cnt == RATIO-1)`.
- `fifo_rd = !rst & !fifo_empty & (!buf_valid | drain)`. This is combinational and never asserted while `fifo_empty`.
- On `fifo_rd`: `buf <= fifo_dout`, `buf_valid <= 1`, `cnt <= 0`.
- On `drain` without `fifo_rd`: `buf_valid <= 0`, `cnt <= 0`.
- On `accept` without `drain`: `cnt <= cnt+1`.
- Outputs:
  - `o_valid = buf_valid`.
  - `o_last = buf_valid & (cnt == RATIO-1)`.
  - `o_data = buf[idx*OUT_WIDTH +: OUT_WIDTH]`, where `idx = cnt` if `MSB_FIRST==0`, else `idx = RATIO-1-cnt`.
- Valid/ready rules:
  - Once `o_valid` rises, `o_valid` and `o_data` remain stable until `accept`.
  - `o_valid` never depends combinationally on `o_ready`.
- `RATIO==1`: the block degenerates to a one-word register slice. `o_last` is always equal to `o_valid`.
- Reset:
  - `buf <= 0`, `buf_valid <= 0`, `cnt <= 0`.
  - Therefore `o_valid=0`, `o_last=0`, `o_data=0`, `fifo_rd=0`.
- Reset mid-word: remaining slices of the buffered word are discarded. The word has already been popped and is lost.

## Timing

- Latency: a word arriving at the FIFO head in cycle t with `buf` empty gives `fifo_rd` high in t and the first slice (`o_valid`=1) in t+1.
- Back-to-back: with `o_ready` held at 1 and the FIFO non-empty, `fifo_rd` pulses exactly in the cycle of each `o_last` accept. Slices are gap-free.
- FIFO empty at `drain`: `o_valid` falls in the next cycle. When a word appears, first-slice latency is 1 cycle.
- `o_ready` low: `cnt` and `buf` are frozen and `fifo_rd` stays 0, even if the FIFO is non-empty and the buffer holds its last slice.
- `fifo_empty` is sampled only in the `fifo_rd` equation. Simultaneous `drain` and `fifo_empty=1` yields no pop.

## Structure

- A shared package `fifo_pkg` holds:
  - the `clog2` function, used for the `cnt` width;
  - an elaboration check that `DATA_WIDTH % OUT_WIDTH == 0` (fatal otherwise).
- No sub-module. The slice mux and control logic are inline.
- The bench instantiates `fifo` with `LOOKAHEAD=1` feeding this block.

## Test plan

- **Ordered stream, LSB first**: push 0x04030201, 0x08070605 with `o_ready`=1.
  - Response: `o_data` = 01,02,03,04,05,06,07,08 on 8 consecutive cycles.
  - `o_last` is high on 04 and 08.
  - `fifo_rd` pulses on cycles 0 and 4 of the stream.
- **MSB first**: with `MSB_FIRST=1`, push 0x04030201.
  - Response: 04,03,02,01, with `o_last` on 01.
- **Backpressure**: drop `o_ready` for 3 cycles while 0x03 is presented.
  - Response: `o_data` holds 0x03 and `o_valid` holds 1.
  - `fifo_rd`=0 for all 3 cycles. The stream resumes with 0x04 and no slice is lost or duplicated.
- **Empty gap**: push one word, wait 5 idle cycles, then push 0x0D0C0B0A.
  - Response: `o_valid` is 0 during the gap.
  - 0A appears 2 cycles after the FIFO write (1 cycle FIFO plus 1 cycle this block).
- **Reset mid-word**: assert `rst` after slice 02 of 0x04030201.
  - Response: the next cycle shows `o_valid`=0, `o_data`=0, `fifo_rd`=0.
  - After reset, the next pushed word 0x0000FFEE emits EE,FF,00,00.
- **Soak**: 1024 random words with random `o_ready`.
  - Response: the scoreboard of reassembled words matches the input exactly.
  - `fifo_rd` is never high while `fifo_empty`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: ceiling log2 for counter/pointer widths
// and the width-divisibility test used by the width converters.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit divides(input int whole, input int part);
    return (part > 0) && ((whole % part) == 0);
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; LOOKAHEAD=1 presents the head word on dout while !empty.
// Writes when full and reads when empty are ignored; DEPTH is a power of two.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit LOOKAHEAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if (LOOKAHEAD) begin : g_fwft
    assign dout = mem[rptr];
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst)        dout_q <= '0;
      else if (do_rd) dout_q <= mem[rptr];
    end
    assign dout = dout_q;
  end

endmodule

// File: rtl/fifo_downsizer.sv
// Splits lookahead-FIFO words into OUT_WIDTH slices; first slice one cycle after pop.
// o_ready low freezes the slice and blocks pops; the next word pops with the last slice.
module fifo_downsizer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_last
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CW    = (clog2(RATIO) > 1) ? clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (!divides(DATA_WIDTH, OUT_WIDTH)) begin : g_bad_width
    $fatal(1, "fifo_downsizer: OUT_WIDTH must divide DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_valid;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  drain;
  int                    idx;

  assign accept  = o_valid & o_ready;
  assign drain   = accept & (cnt == LAST);
  // Refill from the FIFO in the same cycle the last slice leaves, so words run gap-free.
  assign fifo_rd = !rst & !fifo_empty & (!buf_valid | drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data  <= '0;
      buf_valid <= 1'b0;
      cnt       <= '0;
    end else if (fifo_rd) begin
      buf_data  <= fifo_dout;
      buf_valid <= 1'b1;
      cnt       <= '0;
    end else if (drain) begin
      buf_valid <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_valid = buf_valid;
  assign o_last  = buf_valid & (cnt == LAST);

  always_comb begin
    idx    = MSB_FIRST ? (RATIO - 1 - int'(cnt)) : int'(cnt);
    o_data = buf_data[idx*OUT_WIDTH +: OUT_WIDTH];
  end

endmodule

// File: tb/tb_fifo_downsizer.sv
// Directed and random checks of the downsizer behind a lookahead FIFO,
// with an LSB-first instance (A) and an MSB-first instance (B) fed the same stream.
module tb_fifo_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] din;
  logic        o_ready;

  logic        full_a, empty_a, rd_a, o_valid_a, o_last_a;
  logic [31:0] dout_a;
  logic [7:0]  o_data_a;
  logic        full_b, empty_b, rd_b, o_valid_b, o_last_b;
  logic [31:0] dout_b;
  logic [7:0]  o_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo #(.WIDTH(32), .DEPTH(16), .LOOKAHEAD(1'b1)) u_fifo_a (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full_a),
    .rd(rd_a), .dout(dout_a), .empty(empty_a)
  );

  fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_dout(dout_a), .fifo_rd(rd_a),
    .o_valid(o_valid_a), .o_ready(o_ready), .o_data(o_data_a), .o_last(o_last_a)
  );

  fifo #(.WIDTH(32), .DEPTH(16), .LOOKAHEAD(1'b1)) u_fifo_b (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .full(full_b),
    .rd(rd_b), .dout(dout_b), .empty(empty_b)
  );

  fifo_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_dout(dout_b), .fifo_rd(rd_b),
    .o_valid(o_valid_b), .o_ready(o_ready), .o_data(o_data_b), .o_last(o_last_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, sample 1ns later, check instance A or B.
  task automatic cyc(input logic r, input logic w, input logic [31:0] d, input logic rdy,
                     input bit sel_b, input logic erd, input logic ev,
                     input logic [7:0] ed, input logic el, input string tag);
    logic       rd_o, v_o, l_o;
    logic [7:0] d_o;
    @(negedge clk);
    rst = r; wr = w; din = d; o_ready = rdy;
    #1;
    rd_o = sel_b ? rd_b      : rd_a;
    v_o  = sel_b ? o_valid_b : o_valid_a;
    l_o  = sel_b ? o_last_b  : o_last_a;
    d_o  = sel_b ? o_data_b  : o_data_a;
    chk({tag, ".rd"},    32'(rd_o), 32'(erd));
    chk({tag, ".valid"}, 32'(v_o),  32'(ev));
    chk({tag, ".last"},  32'(l_o),  32'(el));
    if (ev) chk({tag, ".data"}, 32'(d_o), 32'(ed));
  endtask

  initial begin
    int          sent, got, ncyc, viol, k;
    logic [31:0] acc;
    logic [31:0] exp_q[$];

    rst = 1'b1; wr = 1'b0; din = '0; o_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, "rst");
    chk("rst.data", 32'(o_data_a), 32'h0);

    // Ordered stream, LSB first
    cyc(0, 1, 32'h04030201, 1, 0, 0, 0, 8'h00, 0, "lsb0");
    cyc(0, 1, 32'h08070605, 1, 0, 1, 0, 8'h00, 0, "lsb1");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h01, 0, "lsb2");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h02, 0, "lsb3");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h03, 0, "lsb4");
    cyc(0, 0, 0, 1, 0, 1, 1, 8'h04, 1, "lsb5");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h05, 0, "lsb6");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h06, 0, "lsb7");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h07, 0, "lsb8");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h08, 1, "lsb9");
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "lsb10");

    // MSB first (instance B)
    cyc(0, 1, 32'h04030201, 1, 1, 0, 0, 8'h00, 0, "msb0");
    cyc(0, 0, 0, 1, 1, 1, 0, 8'h00, 0, "msb1");
    cyc(0, 0, 0, 1, 1, 0, 1, 8'h04, 0, "msb2");
    cyc(0, 0, 0, 1, 1, 0, 1, 8'h03, 0, "msb3");
    cyc(0, 0, 0, 1, 1, 0, 1, 8'h02, 0, "msb4");
    cyc(0, 0, 0, 1, 1, 0, 1, 8'h01, 1, "msb5");
    cyc(0, 0, 0, 1, 1, 0, 0, 8'h00, 0, "msb6");

    // Backpressure on 0x03, then a stall on a last slice with the FIFO non-empty
    cyc(0, 1, 32'h04030201, 1, 0, 0, 0, 8'h00, 0, "bp0");
    cyc(0, 1, 32'h08070605, 1, 0, 1, 0, 8'h00, 0, "bp1");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h01, 0, "bp2");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h02, 0, "bp3");
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h03, 0, "bp4");
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h03, 0, "bp5");
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h03, 0, "bp6");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h03, 0, "bp7");
    cyc(0, 0, 0, 0, 0, 0, 1, 8'h04, 1, "bp8");
    cyc(0, 0, 0, 1, 0, 1, 1, 8'h04, 1, "bp9");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h05, 0, "bp10");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h06, 0, "bp11");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h07, 0, "bp12");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h08, 1, "bp13");
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "bp14");

    // Empty gap between words
    cyc(0, 1, 32'h44332211, 1, 0, 0, 0, 8'h00, 0, "gap0");
    cyc(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, "gap1");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h11, 0, "gap2");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h22, 0, "gap3");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h33, 0, "gap4");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h44, 1, "gap5");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "gap_idle");
    cyc(0, 1, 32'h0D0C0B0A, 1, 0, 0, 0, 8'h00, 0, "gap11");
    cyc(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, "gap12");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h0A, 0, "gap13");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h0B, 0, "gap14");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h0C, 0, "gap15");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h0D, 1, "gap16");
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "gap17");

    // Reset mid-word
    cyc(0, 1, 32'h04030201, 1, 0, 0, 0, 8'h00, 0, "rmw0");
    cyc(0, 1, 32'h08070605, 1, 0, 1, 0, 8'h00, 0, "rmw1");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h01, 0, "rmw2");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h02, 0, "rmw3");
    cyc(1, 0, 0, 1, 0, 0, 1, 8'h03, 0, "rmw4");
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "rmw5");
    chk("rmw5.data", 32'(o_data_a), 32'h0);
    cyc(0, 1, 32'h0000FFEE, 1, 0, 0, 0, 8'h00, 0, "rmw6");
    cyc(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, "rmw7");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'hEE, 0, "rmw8");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'hFF, 0, "rmw9");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h00, 0, "rmw10");
    cyc(0, 0, 0, 1, 0, 0, 1, 8'h00, 1, "rmw11");
    cyc(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, "rmw12");

    // Soak: random writes and random o_ready, reassemble words on instance A
    sent = 0; got = 0; ncyc = 0; viol = 0; k = 0; acc = '0;
    while (got < 1024 && ncyc < 30000) begin
      @(negedge clk);
      rst = 1'b0;
      wr  = (sent < 1024) && !full_a && ($urandom_range(3) != 0);
      if (wr) begin
        din = $urandom;
        exp_q.push_back(din);
        sent++;
      end else begin
        din = '0;
      end
      o_ready = ($urandom_range(3) != 0);
      #1;
      if (rd_a && empty_a) viol++;
      if (o_valid_a && o_ready) begin
        acc[8*k +: 8] = o_data_a;
        if (o_last_a != (k == 3)) viol++;
        if (k == 3) begin
          chk("soak.word", acc, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
          got++;
          k = 0;
        end else begin
          k++;
        end
      end
      ncyc++;
    end
    chk("soak.words", 32'(got), 32'd1024);
    chk("soak.violations", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
